// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame scheduler: FSM states, GRB field
// offsets inside a colour word, and default bit timing at 50 MHz.
package ws2812_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  // Colour word is {G, R, B}; G goes out first.
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  localparam int DEF_T0H_CYC   = 20;
  localparam int DEF_T1H_CYC   = 40;
  localparam int DEF_BIT_CYC   = 60;
  localparam int DEF_LATCH_CYC = 2500;

  // Pack separate channels into the on-wire word layout.
  function automatic logic [23:0] grb(input logic [7:0] g, input logic [7:0] r,
                                      input logic [7:0] b);
    logic [23:0] w;
    w = '0;
    w[G_OFS +: 8] = g;
    w[R_OFS +: 8] = r;
    w[B_OFS +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit NRZ encoder: one start pulse produces one BIT_CYC-long bit cell,
// high for T1H_CYC or T0H_CYC clocks. done marks the last low cycle so the
// next start can be issued in the same cycle with no gap.
module ws2812_bit_tx import ws2812_pkg::*; #(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic start,
  input  logic bit_in,
  output logic data,
  output logic done
);

  localparam logic [5:0] LAST = 6'(BIT_CYC - 1);
  localparam logic [5:0] T0   = 6'(T0H_CYC);
  localparam logic [5:0] T1   = 6'(T1H_CYC);

  logic [5:0] phase_q, phase_d;
  logic       active_q, active_d;
  logic       hi_q, hi_d;
  logic       data_q, data_d;

  assign done = active_q && (phase_q == LAST);
  assign data = data_q;

  // Phase walk: data for the next cycle is registered so the pin is glitch-free.
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    hi_d     = hi_q;
    data_d   = data_q;
    if (start) begin
      active_d = 1'b1;
      phase_d  = '0;
      hi_d     = bit_in;
      data_d   = 1'b1;
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
        phase_d  = '0;
        data_d   = 1'b0;
      end else begin
        phase_d = phase_q + 6'd1;
        data_d  = (phase_q + 6'd1) < (hi_q ? T1 : T0);
      end
    end
  end

  // Encoder state; reset forces the line low immediately.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      hi_q     <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Walks the pixel RAM and streams each 24-bit GRB word MSB-first through the
// bit encoder, then holds the line low for the latch gap. The next pixel is
// read during the last bit of the current one so bits stay back-to-back.
module ws2812_frame_scheduler import ws2812_pkg::*; #(
  parameter  int NUM_PIXELS = 16,
  parameter  int T0H_CYC    = DEF_T0H_CYC,
  parameter  int T1H_CYC    = DEF_T1H_CYC,
  parameter  int BIT_CYC    = DEF_BIT_CYC,
  parameter  int LATCH_CYC  = DEF_LATCH_CYC,
  localparam int AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic          data
);

  localparam int            MSB      = G_OFS + 7;
  localparam int            LW       = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
  localparam logic [AW-1:0] LAST_PIX = AW'(NUM_PIXELS - 1);
  localparam logic [AW:0]   NPIX     = (AW + 1)'(NUM_PIXELS);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYC - 1);

  logic [23:0]   mem [NUM_PIXELS];
  logic [23:0]   rd_data_q, rd_data_d;
  logic [AW-1:0] rd_addr;

  logic [1:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          pend_q, pend_d;
  logic          cap_q, cap_d;     // first SEND cycle: capture the LOAD read
  logic [AW-1:0] pix_q, pix_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [23:0]   shift_q, shift_d;

  logic          tx_start, tx_bit, tx_done;

  assign busy      = busy_q;
  assign rd_data_d = mem[rd_addr];

  // Pixel RAM: out-of-range writes dropped, registered read returns the old word.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && ({1'b0, wr_addr} < NPIX)) mem[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  // Frame sequencing: acceptance, per-bit handoff to the encoder, latch gap.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    pend_d     = pend_q;
    cap_d      = cap_q;
    pix_d      = pix_q;
    bcnt_d     = bcnt_q;
    lat_d      = lat_q;
    shift_d    = shift_q;
    tx_start   = 1'b0;
    tx_bit     = shift_q[MSB];
    rd_addr    = pix_q;
    frame_done = 1'b0;
    if (frame_start && (state_q != ST_IDLE)) pend_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (frame_start || pend_q) begin
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          pix_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cap_d   = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        // Last bit of a pixel: prefetch the next word so it is ready at done.
        if (bcnt_q == 5'd0) rd_addr = pix_q + 1'b1;
        if (cap_q) begin
          cap_d    = 1'b0;
          shift_d  = rd_data_q;
          bcnt_d   = 5'd23;
          tx_start = 1'b1;
          tx_bit   = rd_data_q[MSB];
        end else if (tx_done) begin
          if (bcnt_q != 5'd0) begin
            shift_d  = {shift_q[22:0], 1'b0};
            bcnt_d   = bcnt_q - 5'd1;
            tx_start = 1'b1;
            tx_bit   = shift_q[MSB-1];
          end else if (pix_q == LAST_PIX) begin
            lat_d   = '0;
            state_d = ST_LATCH;
          end else begin
            pix_d    = pix_q + 1'b1;
            shift_d  = rd_data_q;
            bcnt_d   = 5'd23;
            tx_start = 1'b1;
            tx_bit   = rd_data_q[MSB];
          end
        end
      end
      default: begin
        if (lat_q == LAT_LAST) begin
          frame_done = 1'b1;
          busy_d     = 1'b0;
          lat_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      cap_q   <= 1'b0;
      pix_q   <= '0;
      bcnt_q  <= '0;
      lat_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      cap_q   <= cap_d;
      pix_q   <= pix_d;
      bcnt_q  <= bcnt_d;
      lat_q   <= lat_d;
      shift_q <= shift_d;
    end
  end

  ws2812_bit_tx #(
    .T0H_CYC(T0H_CYC),
    .T1H_CYC(T1H_CYC),
    .BIT_CYC(BIT_CYC)
  ) u_bit_tx (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .start   (tx_start),
    .bit_in  (tx_bit),
    .data    (data),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Scoreboard bench: a timing-level model pushes expected pixel words (with the
// cycle their first bit must rise) and frame_done cycles; a monitor decodes the
// data line into words and pops/compares.
module tb_ws2812_frame_scheduler;
  import ws2812_pkg::*;

  localparam int NP    = 3;
  localparam int BITC  = 60;
  localparam int LATCH = 2500;
  localparam int PIXC  = 24 * BITC;
  localparam int FRAME = 3 + NP * PIXC + LATCH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        frame_start = 1'b0;
  logic        busy, frame_done, data;

  always #10 clk = ~clk;

  ws2812_frame_scheduler #(.NUM_PIXELS(NP)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_start(frame_start),
    .busy       (busy),
    .frame_done (frame_done),
    .data       (data)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int t; logic [23:0] w; int p; } px_t;
  px_t         exp_px[$];
  int          exp_done[$];
  logic [23:0] mram [NP];
  int          cyc = 0;
  bit          m_act = 0, m_pend = 0;
  int          m_start = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_pend = 0;
      exp_px.delete(); exp_done.delete();
    end else begin
      if (wr_en && wr_addr < NP) mram[wr_addr] = wr_data;
      if (frame_start) begin
        if (!m_act) begin
          m_act = 1; m_start = cyc;
          exp_done.push_back(cyc + FRAME - 1);
        end else if (cyc != m_start) m_pend = 1;
      end
      if (m_act) begin
        for (int p = 0; p < NP; p++)
          if (cyc + 1 == m_start + 3 + p * PIXC)
            exp_px.push_back('{m_start + 3 + p * PIXC, mram[p], p});
        if (cyc == m_start + FRAME - 1) begin
          m_act = 0;
          if (m_pend) begin
            m_pend = 0; m_act = 1; m_start = cyc + 1;
            exp_done.push_back(cyc + FRAME);
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  logic        prev = 1'b0;
  int          rise_t = 0, bidx = 0, ndone = 0;
  logic [23:0] acc = '0;
  px_t         cur;
  bit          bad = 0, chk_fall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 1'b0; bidx = 0; bad = 0; chk_fall = 0;
    end else begin
      if (chk_fall) begin chk("busy_fall", int'(busy), 0); chk_fall = 0; end
      if (data && !prev) begin
        if (bidx == 0) begin
          if (exp_px.size() == 0) begin
            checks++;
            $display("FAIL unexpected_bit: data rose at cycle %0d, expected line idle", cyc);
            cur = '{cyc, 24'h0, -1};
          end else begin
            cur = exp_px.pop_front();
            chk($sformatf("px%0d_start_cycle", cur.p), cyc, cur.t);
          end
          bad = 0;
        end else if (cyc - rise_t != BITC) bad = 1;
        rise_t = cyc;
      end
      if (!data && prev) begin
        if (cyc - rise_t == 40)      acc = {acc[22:0], 1'b1};
        else if (cyc - rise_t == 20) acc = {acc[22:0], 1'b0};
        else begin acc = {acc[22:0], 1'b0}; bad = 1; end
        bidx++;
        if (bidx == 24) begin
          chk($sformatf("px%0d_word", cur.p), int'(acc), int'(cur.w));
          chk($sformatf("px%0d_bit_timing_ok", cur.p), int'(bad), 0);
          bidx = 0;
        end
      end
      if (frame_done) begin
        ndone++;
        if (exp_done.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame_done: pulse at cycle %0d, expected none", cyc);
        end else begin
          chk("frame_done_cycle", cyc, exp_done.pop_front());
          chk("busy_at_done", int'(busy), 1);
          chk_fall = 1;
        end
      end
      prev = data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int a, input logic [23:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a[1:0]; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic start(output int n);
    @(negedge clk); frame_start = 1'b1; n = cyc;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_quiet(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((m_act || m_pend || busy) && n < 3 * FRAME) begin @(negedge clk); n++; end
    if (n >= 3 * FRAME) begin
      checks++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", nm, n);
    end
  endtask

  initial begin
    int n, d0;
    repeat (3) @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with known pulse pattern.
    wr(0, grb(8'hFF, 8'h00, 8'h00));
    wr(1, grb(8'h00, 8'h00, 8'h01));
    wr(2, 24'($urandom));
    start(n);
    wait_cyc(n + 3);
    chk("busy_at_n3", int'(busy), 1);
    chk("data_at_n3", int'(data), 1);
    wait_quiet("frame1");

    // Two requests while busy -> exactly one extra frame.
    wr(2, 24'($urandom));
    start(n);
    wait_cyc(n + 100); pulse();
    wait_cyc(n + 300); pulse();
    wait_quiet("double_start");

    // Mid-frame writes: pixel1/2 change in this frame, pixel0 only in the next.
    wr(2, 24'($urandom));
    start(n);
    wait_cyc(n + 3 + 700);
    wr(1, 24'hAAAAAA);
    wr(0, 24'($urandom));
    wait_cyc(n + 3 + PIXC + 700);
    wr(2, 24'($urandom));
    wait_quiet("midframe_wr");
    start(n);
    wait_quiet("after_midframe");

    // Out-of-range write leaves the RAM unchanged.
    wr(3, 24'($urandom));
    start(n);
    wait_quiet("oob_wr");

    // Reset in the high phase of bit 10 of pixel 0.
    start(n);
    wait_cyc(n + 3 + 10 * BITC + 5);
    #2;
    chk("pre_reset_data", int'(data), 1);
    d0 = ndone;
    rst_n = 1'b0;
    #1;
    chk("reset_async_data", int'(data), 0);
    chk("reset_async_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cyc(cyc + FRAME);
    chk("no_done_after_reset", ndone, d0);
    chk("idle_after_reset", int'(busy), 0);

    // Normal frame after reset.
    for (int p = 0; p < NP; p++) wr(p, 24'($urandom));
    start(n);
    wait_quiet("post_reset");

    repeat (5) @(negedge clk);
    chk("px_queue_empty", exp_px.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("decoder_idle", bidx, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
